// File: rtl/ad_ip_jesd204_tpl_adc_pn_mon_if.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pn_mon_if
//
// Bundles one channel's receive beat and the PN monitor status that goes back
// to the register map.
//
//   adc_valid       beat qualifier
//   adc_data        DATA_WIDTH-bit beat, sample 0 in the LSBs
//   adc_pn_sel      0 = PN7, 1 = PN15
//   adc_pn_clr      single-cycle pulse clearing the error status
//   adc_pn_oos      1 = not locked to the pattern
//   adc_pn_err      sticky error flag
//   adc_pn_err_cnt  saturating count of mismatching beats while locked
//
// Modports:
//   master  the side feeding beats (deframer / register map)
//   slave   the PN monitor
// ---------------------------------------------------------------------------
interface ad_ip_jesd204_tpl_adc_pn_mon_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ERR_CNT_WIDTH = 16
);

  logic                     adc_valid;
  logic [DATA_WIDTH-1:0]    adc_data;
  logic                     adc_pn_sel;
  logic                     adc_pn_clr;
  logic                     adc_pn_oos;
  logic                     adc_pn_err;
  logic [ERR_CNT_WIDTH-1:0] adc_pn_err_cnt;

  modport master (
    output adc_valid,
    output adc_data,
    output adc_pn_sel,
    output adc_pn_clr,
    input  adc_pn_oos,
    input  adc_pn_err,
    input  adc_pn_err_cnt
  );

  modport slave (
    input  adc_valid,
    input  adc_data,
    input  adc_pn_sel,
    input  adc_pn_clr,
    output adc_pn_oos,
    output adc_pn_err,
    output adc_pn_err_cnt
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pn_mon.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pn_mon
//
// Per-channel PN7 / PN15 checker for the ADC transport layer. Each valid beat
// is serialised (sample 0 first, MSB of each sample first) and every bit is
// checked against the XOR of the two tap bits taken from the received stream
// itself, so the checker resynchronises on its own after any disturbance.
// An out-of-sync state machine turns the per-beat match result into lock
// status, and mismatches while locked are reported as errors.
//
// Ports:
//   clk    core clock
//   reset  asynchronous, active-high reset
//   pn     ad_ip_jesd204_tpl_adc_pn_mon_if.slave
//            adc_valid / adc_data / adc_pn_sel / adc_pn_clr  in
//            adc_pn_oos / adc_pn_err / adc_pn_err_cnt        out
//
// Configuration macro:
//   AD_IP_JESD204_TPL_ADC_PN_ERR_CNT_EN
//     defined   : saturating adc_pn_err_cnt is built
//     undefined : adc_pn_err_cnt is tied to 0
//
// DATA_PATH_WIDTH * CONVERTER_RESOLUTION must be at least 15 so that the
// history of the previous beat can always be taken from a single beat.
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_pn_mon #(
  parameter int DATA_PATH_WIDTH      = 4,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int OOS_THRESHOLD        = 16,
  parameter int ERR_CNT_WIDTH        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  ad_ip_jesd204_tpl_adc_pn_mon_if.slave       pn
);

  localparam int N  = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
  localparam int CR = CONVERTER_RESOLUTION;
  localparam int HW = 15;                          // history depth (longest tap)
  localparam int CW = $clog2(OOS_THRESHOLD + 1);
  localparam logic [CW-1:0] THR_LAST = CW'(OOS_THRESHOLD - 1);

  typedef enum logic {
    ST_OOS    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_reg;
  logic            oos_reg;
  logic            err_reg;
  logic            sel_reg;
  logic [CW-1:0]   match_cnt_reg;
  logic [CW-1:0]   miss_cnt_reg;
  logic [HW-1:0]   hist_reg;    // hist_reg[0] is the oldest bit, s[-15]

  logic [N-1:0]    ser;         // ser[k] = serial bit k of the current beat
  logic [N+HW-1:0] ext;         // history followed by the current beat
  logic [N-1:0]    pred;
  logic            beat_match;
  logic            sel_chg;

  // Serial order: sample 0 first, MSB of each sample first.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ser
      assign ser[gi] = pn.adc_data[(gi / CR) * CR + CR - 1 - (gi % CR)];
    end
  endgenerate

  assign ext = {ser, hist_reg};

  // Bit k sits at ext[HW+k]; PN7 taps are k-6 / k-7, PN15 taps are k-14 / k-15.
  generate
    for (gi = 0; gi < N; gi++) begin : g_pred
      assign pred[gi] = pn.adc_pn_sel ? (ext[gi + 1] ^ ext[gi])
                                      : (ext[gi + 9] ^ ext[gi + 8]);
    end
  endgenerate

  // An all-zero beat satisfies any XOR recurrence trivially, so it is
  // rejected explicitly to avoid locking onto a dead link.
  assign beat_match = (ser == pred) && (|pn.adc_data);
  assign sel_chg    = (pn.adc_pn_sel != sel_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_OOS;
      oos_reg       <= 1'b1;
      err_reg       <= 1'b0;
      sel_reg       <= 1'b0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      hist_reg      <= '0;
    end else begin
      sel_reg <= pn.adc_pn_sel;
      if (sel_chg) begin
        // New pattern: drop lock and restart from an empty history; the beat
        // arriving with the change is discarded.
        state_reg     <= ST_OOS;
        oos_reg       <= 1'b1;
        match_cnt_reg <= '0;
        miss_cnt_reg  <= '0;
        hist_reg      <= '0;
      end else if (pn.adc_valid) begin
        hist_reg <= ext[N+HW-1:N];
        case (state_reg)
          ST_OOS: begin
            if (beat_match) begin
              if (match_cnt_reg == THR_LAST) begin
                state_reg     <= ST_LOCKED;
                oos_reg       <= 1'b0;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
              end else begin
                match_cnt_reg <= match_cnt_reg + CW'(1);
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end
          ST_LOCKED: begin
            if (!beat_match) begin
              err_reg <= 1'b1;
              if (miss_cnt_reg == THR_LAST) begin
                state_reg     <= ST_OOS;
                oos_reg       <= 1'b1;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
              end else begin
                miss_cnt_reg <= miss_cnt_reg + CW'(1);
              end
            end else begin
              miss_cnt_reg <= '0;
            end
          end
          default: begin
            state_reg <= ST_OOS;
            oos_reg   <= 1'b1;
          end
        endcase
      end
      // Clear has priority over a simultaneous mismatch.
      if (pn.adc_pn_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

`ifdef AD_IP_JESD204_TPL_ADC_PN_ERR_CNT_EN
  logic                     lock_miss;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

  assign lock_miss = !sel_chg && pn.adc_valid && (state_reg == ST_LOCKED) && !beat_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_reg <= '0;
    end else if (pn.adc_pn_clr) begin
      err_cnt_reg <= '0;
    end else if (lock_miss && !(&err_cnt_reg)) begin
      err_cnt_reg <= err_cnt_reg + ERR_CNT_WIDTH'(1);
    end
  end

  assign pn.adc_pn_err_cnt = err_cnt_reg;
`else
  assign pn.adc_pn_err_cnt = '0;
`endif

  assign pn.adc_pn_oos = oos_reg;
  assign pn.adc_pn_err = err_reg;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_mon.sv
module tb_ad_ip_jesd204_tpl_adc_pn_mon;

  localparam int DPW = 4;
  localparam int CR  = 16;
  localparam int N   = DPW * CR;
  localparam int W   = 16;
  localparam int THR = 16;
  localparam logic [N-1:0] FLIP = 64'h0000_0000_0000_8000; // serial bit 0

`ifdef AD_IP_JESD204_TPL_ADC_PN_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ad_ip_jesd204_tpl_adc_pn_mon_if #(.DATA_WIDTH(N), .ERR_CNT_WIDTH(W)) pn ();

  ad_ip_jesd204_tpl_adc_pn_mon #(
    .DATA_PATH_WIDTH      (DPW),
    .CONVERTER_RESOLUTION (CR),
    .OOS_THRESHOLD        (THR),
    .ERR_CNT_WIDTH        (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pn    (pn.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         oos;
    logic         err;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_beats  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_oos;
  bit           m_err;
  logic [W-1:0] m_cnt;
  int           m_mc;
  int           m_xc;
  bit           m_sel;
  bit [14:0]    m_hist;   // m_hist[0] = s[-15]

  task automatic model_reset();
    m_oos = 1'b1; m_err = 1'b0; m_cnt = '0; m_mc = 0; m_xc = 0;
    m_sel = 1'b0; m_hist = '0;
  endtask

  // Serial recurrence check written directly from the polynomial taps.
  function automatic bit ref_match(input logic [N-1:0] d, input bit sel, output bit [14:0] nh);
    bit x[N+15];
    bit ok;
    int ta, tb;
    ok = 1'b1;
    ta = sel ? 14 : 6;
    tb = sel ? 15 : 7;
    for (int i = 0; i < 15; i++) x[i] = m_hist[i];
    for (int k = 0; k < N; k++) x[15 + k] = d[(k / CR) * CR + CR - 1 - (k % CR)];
    for (int k = 0; k < N; k++)
      if (x[15 + k] != (x[15 + k - ta] ^ x[15 + k - tb])) ok = 1'b0;
    for (int i = 0; i < 15; i++) nh[i] = x[N + i];
    return ok && (d != '0);
  endfunction

  task automatic model_step(input bit v, input logic [N-1:0] d, input bit sel, input bit clr);
    bit [14:0] nh;
    bit        mt;
    if (sel != m_sel) begin
      m_sel = sel; m_oos = 1'b1; m_mc = 0; m_xc = 0; m_hist = '0;
    end else if (v) begin
      mt = ref_match(d, sel, nh);
      m_hist = nh;
      if (m_oos) begin
        if (mt) begin
          m_mc++;
          if (m_mc == THR) begin m_oos = 1'b0; m_mc = 0; m_xc = 0; end
        end else m_mc = 0;
      end else begin
        if (!mt) begin
          m_err = 1'b1;
          if (CNT_EN && m_cnt != '1) m_cnt = m_cnt + 1'b1;
          m_xc++;
          if (m_xc == THR) begin m_oos = 1'b1; m_mc = 0; m_xc = 0; end
        end else m_xc = 0;
      end
    end
    if (clr) begin m_err = 1'b0; m_cnt = '0; end
    exp_q.push_back({m_oos, m_err, m_cnt});
  endtask

  // ---------------- PN source (DAC generator model) ----------------
  bit [14:0] g_last;   // g_last[j-1] = s[k-j]
  int        g_cnt;
  bit        g_sel;

  task automatic g_restart(input bit sel);
    g_sel = sel; g_cnt = 0; g_last = '0;
  endtask

  task automatic gen_beat(output logic [N-1:0] d);
    bit b;
    int len;
    len = g_sel ? 15 : 7;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (g_cnt < len) b = (g_cnt == 0);           // seed 1,0,0,...
      else             b = g_sel ? (g_last[13] ^ g_last[14]) : (g_last[5] ^ g_last[6]);
      g_last = {g_last[13:0], b};
      g_cnt++;
      d[(k / CR) * CR + CR - 1 - (k % CR)] = b;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [N-1:0] d, input bit sel, input bit clr);
    @(negedge clk);
    pn.adc_valid  = v;
    pn.adc_data   = d;
    pn.adc_pn_sel = sel;
    pn.adc_pn_clr = clr;
    model_step(v, d, sel, clr);
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_beats++;
        check("sb_oos", pn.adc_pn_oos, e.oos);
        check("sb_err", pn.adc_pn_err, e.err);
        check("sb_cnt", pn.adc_pn_err_cnt, e.cnt);
        $display("txn %0d oos=%0b err=%0b cnt=%0d", n_beats, pn.adc_pn_oos, pn.adc_pn_err, pn.adc_pn_err_cnt);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] d;
    int nv;
    int total;

    pn.adc_valid = 1'b0; pn.adc_data = '0; pn.adc_pn_sel = 1'b0; pn.adc_pn_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_oos", pn.adc_pn_oos, 1);
    check("reset_err", pn.adc_pn_err, 0);
    check("reset_cnt", pn.adc_pn_err_cnt, 0);

    // 1: PN7 lock after seed + 16 matches
    g_restart(1'b0);
    for (int i = 1; i <= 40; i++) begin
      gen_beat(d);
      drive(1'b1, d, 1'b0, 1'b0);
      if (i == 16) check("t1_oos_beat16", pn.adc_pn_oos, 1);
      if (i == 17) check("t1_oos_beat17", pn.adc_pn_oos, 0);
    end
    check("t1_err", pn.adc_pn_err, 0);
    check("t1_cnt", pn.adc_pn_err_cnt, 0);

    // 2: three single-bit errors while locked, then clear
    for (int i = 0; i < 8; i++) begin
      gen_beat(d);
      drive(1'b1, (i == 1 || i == 4 || i == 6) ? (d ^ FLIP) : d, 1'b0, 1'b0);
    end
    check("t2_err", pn.adc_pn_err, 1);
    check("t2_cnt", pn.adc_pn_err_cnt, CNT_EN ? 3 : 0);
    check("t2_oos", pn.adc_pn_oos, 0);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t2_clr_err", pn.adc_pn_err, 0);
    check("t2_clr_cnt", pn.adc_pn_err_cnt, 0);

    // 3: sixteen all-zero beats drop lock
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, '0, 1'b0, 1'b0);
      if (i == 15) check("t3_oos_beat15", pn.adc_pn_oos, 0);
    end
    check("t3_oos_beat16", pn.adc_pn_oos, 1);
    check("t3_cnt", pn.adc_pn_err_cnt, CNT_EN ? 16 : 0);
    drive(1'b0, '0, 1'b0, 1'b1);

    // 4: relock on PN7, then switch to PN15
    for (int i = 1; i <= 20; i++) begin
      gen_beat(d);
      drive(1'b1, d, 1'b0, 1'b0);
      if (i == 16) check("t4_pn7_oos_beat16", pn.adc_pn_oos, 1);
      if (i == 17) check("t4_pn7_oos_beat17", pn.adc_pn_oos, 0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    check("t4_sel_oos", pn.adc_pn_oos, 1);
    g_restart(1'b1);
    for (int i = 1; i <= 17; i++) begin
      gen_beat(d);
      drive(1'b1, d, 1'b1, 1'b0);
      if (i == 16) check("t4_pn15_oos_beat16", pn.adc_pn_oos, 1);
      if (i == 17) check("t4_pn15_oos_beat17", pn.adc_pn_oos, 0);
    end

    // asynchronous reset mid-operation
    gen_beat(d);
    drive(1'b1, d ^ FLIP, 1'b1, 1'b0);
    check("rst_pre_err", pn.adc_pn_err, 1);
    pn.adc_valid = 1'b0; pn.adc_pn_sel = 1'b0; pn.adc_pn_clr = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_async_oos", pn.adc_pn_oos, 1);
    check("rst_async_err", pn.adc_pn_err, 0);
    check("rst_async_cnt", pn.adc_pn_err_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // 5: PN15 with valid toggling every cycle
    drive(1'b0, '0, 1'b1, 1'b0);
    g_restart(1'b1);
    nv = 0;
    for (int i = 0; i < 34; i++) begin
      if (i % 2 == 0) begin
        gen_beat(d);
        drive(1'b1, d, 1'b1, 1'b0);
        nv++;
        if (nv == 16) check("t5_oos_valid16", pn.adc_pn_oos, 1);
      end else begin
        drive(1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b0);
        if (nv == 17) check("t5_oos_valid17", pn.adc_pn_oos, 0);
      end
    end
    check("t5_err", pn.adc_pn_err, 0);
    gen_beat(d); drive(1'b1, d ^ FLIP, 1'b1, 1'b0);
    check("t5_err_set", pn.adc_pn_err, 1);
    gen_beat(d); drive(1'b1, d, 1'b1, 1'b0);
    gen_beat(d); drive(1'b1, d ^ FLIP, 1'b1, 1'b1);
    check("t5_clr_wins_err", pn.adc_pn_err, 0);
    check("t5_clr_wins_cnt", pn.adc_pn_err_cnt, 0);
    gen_beat(d); drive(1'b1, d, 1'b1, 1'b0);

    // 6: saturation (short burst when the counter is not built)
    total = CNT_EN ? ((1 << W) + 5) : 40;
    for (int i = 0; i < total; i++) begin
      gen_beat(d);
      drive(1'b1, d ^ FLIP, 1'b1, 1'b0);
      if (i % 15 == 14) begin
        gen_beat(d);
        drive(1'b1, d, 1'b1, 1'b0);
      end
    end
    check("t6_cnt", pn.adc_pn_err_cnt, CNT_EN ? 32'h0000_FFFF : 0);
    check("t6_oos", pn.adc_pn_oos, 0);
    check("t6_err", pn.adc_pn_err, 1);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
